// File: rtl/weights_arb_pkg.sv
// Shared widths, FSM state encoding and read-owner encoding for the weights port arbiter.
package weights_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK1 = 2'd1,
        LOCK2 = 2'd2
    } arb_state_e;

    // Which requester a returning read belongs to.
    typedef enum logic {
        OWN_1 = 1'b0,
        OWN_2 = 1'b1
    } owner_e;

endpackage

// File: rtl/weights_rd_pipe.sv
// Valid/owner shift pipeline that tracks granted reads until the memory returns data.
module weights_rd_pipe
    import weights_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  owner_e owner_i,
    output logic   vld_o,
    output owner_e owner_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] own_q;

    // Valid bits shift one stage per clock; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Owner tags travel alongside the valid bits; they are only looked at when valid.
    always_ff @(posedge clk) begin
        own_q[0] <= owner_i;
        for (int i = 1; i < DEPTH; i++) begin
            own_q[i] <= own_q[i-1];
        end
    end

    assign vld_o   = vld_q[DEPTH-1];
    assign owner_o = owner_e'(own_q[DEPTH-1]);

endmodule

// File: rtl/weights_port_arbiter.sv
// Two-requester arbiter in front of the single-port weights memory (port A):
// alternating priority on conflict, burst locking, and a read-return tracker.
module weights_port_arbiter
    import weights_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_1,
    input  logic              req_2,
    input  logic              lock_1,
    input  logic              lock_2,
    input  logic              we_1,
    input  logic              we_2,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [DATA_W-1:0] wdata_2,
    output logic              gnt_1,
    output logic              gnt_2,
    output logic              rvalid_1,
    output logic              rvalid_2,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address_a_1,
    output logic [ADDR_W-1:0] address_a_2,
    output logic              select,
    output logic [DATA_W-1:0] data_a,
    output logic              wren_a,
    input  logic [DATA_W-1:0] q_a
);

    arb_state_e state_q, state_d;
    // 1 = requester 1 was granted most recently, so requester 2 wins the next conflict.
    logic       last_grant_q;
    logic       select_q;
    logic       rd_push;
    owner_e     rd_owner;
    logic       pipe_vld;
    owner_e     pipe_owner;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter a lock on a locked grant, leave once the owner lets go.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_1 && lock_1) begin
                    state_d = LOCK1;
                end else if (gnt_2 && lock_2) begin
                    state_d = LOCK2;
                end
            end
            LOCK1:   if (!req_1 || !lock_1) state_d = IDLE;
            LOCK2:   if (!req_2 || !lock_2) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grants; a lock shuts out the other requester regardless of priority.
    always_comb begin
        gnt_1 = 1'b0;
        gnt_2 = 1'b0;
        if (!rst) begin
            case (state_q)
                LOCK1: gnt_1 = req_1;
                LOCK2: gnt_2 = req_2;
                default: begin
                    if (req_1 && req_2) begin
                        gnt_1 = !last_grant_q;
                        gnt_2 = last_grant_q;
                    end else begin
                        gnt_1 = req_1;
                        gnt_2 = req_2;
                    end
                end
            endcase
        end
    end

    // Memory port steering follows the granted requester; select holds when idle.
    always_comb begin
        select = select_q;
        data_a = '0;
        wren_a = 1'b0;
        if (gnt_1) begin
            select = 1'b0;
            data_a = wdata_1;
            wren_a = we_1;
        end else if (gnt_2) begin
            select = 1'b1;
            data_a = wdata_2;
            wren_a = we_2;
        end
    end

    // Priority history and held select value.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
            select_q     <= 1'b0;
        end else begin
            select_q <= select;
            if (gnt_1) begin
                last_grant_q <= 1'b1;
            end else if (gnt_2) begin
                last_grant_q <= 1'b0;
            end
        end
    end

    assign rd_push  = (gnt_1 && !we_1) || (gnt_2 && !we_2);
    assign rd_owner = gnt_2 ? OWN_2 : OWN_1;

    weights_rd_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .push_i (rd_push),
        .owner_i(rd_owner),
        .vld_o  (pipe_vld),
        .owner_o(pipe_owner)
    );

    assign rvalid_1    = !rst && pipe_vld && (pipe_owner == OWN_1);
    assign rvalid_2    = !rst && pipe_vld && (pipe_owner == OWN_2);
    assign rdata       = q_a;
    assign address_a_1 = addr_1;
    assign address_a_2 = addr_2;

endmodule

// File: tb/tb_weights_port_arbiter.sv
// Scoreboard bench: two arbiters (read latency 2 and 1) share stimulus, each with its own memory model.
module tb_weights_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_clr;
    logic        req_1, req_2, lock_1, lock_2, we_1, we_2;
    logic [11:0] addr_1, addr_2;
    logic [31:0] wdata_1, wdata_2;

    logic        a_gnt_1, a_gnt_2, a_rv_1, a_rv_2, a_sel, a_wren;
    logic [31:0] a_rdata, a_data, a_q;
    logic [11:0] a_ad1, a_ad2;
    logic        b_gnt_1, b_gnt_2, b_rv_1, b_rv_2, b_sel, b_wren;
    logic [31:0] b_rdata, b_data, b_q;
    logic [11:0] b_ad1, b_ad2;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        own;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb_a[$];
    exp_t sb_b[$];

    weights_port_arbiter #(.READ_LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2), .lock_1(lock_1), .lock_2(lock_2),
        .we_1(we_1), .we_2(we_2), .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
        .gnt_1(a_gnt_1), .gnt_2(a_gnt_2), .rvalid_1(a_rv_1), .rvalid_2(a_rv_2), .rdata(a_rdata),
        .address_a_1(a_ad1), .address_a_2(a_ad2), .select(a_sel), .data_a(a_data), .wren_a(a_wren), .q_a(a_q)
    );

    weights_port_arbiter #(.READ_LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2), .lock_1(lock_1), .lock_2(lock_2),
        .we_1(we_1), .we_2(we_2), .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
        .gnt_1(b_gnt_1), .gnt_2(b_gnt_2), .rvalid_1(b_rv_1), .rvalid_2(b_rv_2), .rdata(b_rdata),
        .address_a_1(b_ad1), .address_a_2(b_ad2), .select(b_sel), .data_a(b_data), .wren_a(b_wren), .q_a(b_q)
    );

    // Unwritten locations read back a fixed pattern; 0x010 holds 0xDEADBEEF.
    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {20'hA5A50, a};
    endfunction

    // Memory model for the latency-2 build.
    logic [31:0] mem_a [4096];
    logic [4095:0] wr_a;
    logic [11:0] ap_a0, ap_a1;
    wire  [11:0] maddr_a = a_sel ? a_ad2 : a_ad1;
    always @(posedge clk) begin
        if (mem_clr) wr_a <= '0;
        else if (a_wren) begin
            mem_a[maddr_a] <= a_data;
            wr_a[maddr_a]  <= 1'b1;
        end
        ap_a0 <= maddr_a;
        ap_a1 <= ap_a0;
    end
    assign a_q = wr_a[ap_a1] ? mem_a[ap_a1] : init_val(ap_a1);

    // Memory model for the latency-1 build.
    logic [31:0] mem_b [4096];
    logic [4095:0] wr_b;
    logic [11:0] ap_b0;
    wire  [11:0] maddr_b = b_sel ? b_ad2 : b_ad1;
    always @(posedge clk) begin
        if (mem_clr) wr_b <= '0;
        else if (b_wren) begin
            mem_b[maddr_b] <= b_data;
            wr_b[maddr_b]  <= 1'b1;
        end
        ap_b0 <= maddr_b;
    end
    assign b_q = wr_b[ap_b0] ? mem_b[ap_b0] : init_val(ap_b0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Compare one returned read (or a missing one) against the head of a scoreboard.
    task automatic mon(input int which, input logic rv1, input logic rv2, input logic [31:0] rd);
        exp_t e;
        int   sz;
        sz = (which == 0) ? sb_a.size() : sb_b.size();
        if (sz > 0) begin
            e = (which == 0) ? sb_a[0] : sb_b[0];
            if (e.due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_rvalid dut%0d @cyc %0d: got none expected owner %0d data %h", which, cyc, e.own + 1, e.data);
                if (which == 0) void'(sb_a.pop_front()); else void'(sb_b.pop_front());
                sz--;
            end
        end
        if (rv1 || rv2) begin
            n_vec++;
            if (rv1 && rv2) begin
                n_err++;
                $display("FAIL rvalid_both dut%0d @cyc %0d: got 11 expected one-hot", which, cyc);
            end else if (sz == 0) begin
                n_err++;
                $display("FAIL rvalid_spurious dut%0d @cyc %0d: got rvalid %b%b expected 00", which, cyc, rv2, rv1);
            end else begin
                if (which == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                if (rv2 !== e.own || rd !== e.data || cyc != e.due) begin
                    n_err++;
                    $display("FAIL rvalid_ret dut%0d @cyc %0d: got owner %0d data %h expected owner %0d data %h cyc %0d",
                             which, cyc, rv2 + 1, rd, e.own + 1, e.data, e.due);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_rv_1, a_rv_2, a_rdata);
        mon(1, b_rv_1, b_rv_2, b_rdata);
    end

    // One clock of stimulus; checks combinational outputs and queues the expected read return.
    task automatic step(input logic rs,
                        input logic r1, input logic l1, input logic w1, input logic [11:0] a1, input logic [31:0] d1,
                        input logic r2, input logic l2, input logic w2, input logic [11:0] a2, input logic [31:0] d2,
                        input logic eg1, input logic eg2, input logic [31:0] erd, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rs; req_1 = r1; lock_1 = l1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
        req_2 = r2; lock_2 = l2; we_2 = w2; addr_2 = a2; wdata_2 = d2;
        if (rs) begin
            sb_a.delete();
            sb_b.delete();
        end
        @(negedge clk);
        chk({nm, ".gnt"},   {30'b0, a_gnt_2, a_gnt_1}, {30'b0, eg2, eg1});
        chk({nm, ".gnt_b"}, {30'b0, b_gnt_2, b_gnt_1}, {30'b0, eg2, eg1});
        chk({nm, ".wren"},  {31'b0, a_wren}, {31'b0, (eg1 & w1) | (eg2 & w2)});
        chk({nm, ".data_a"}, a_data, eg1 ? d1 : (eg2 ? d2 : 32'h0));
        chk({nm, ".addr_pass"}, {8'b0, a_ad2, a_ad1}, {8'b0, a2, a1});
        if (eg1 || eg2) chk({nm, ".select"}, {31'b0, a_sel}, {31'b0, eg2});
        if (rs) begin
            chk({nm, ".select_rst"}, {31'b0, a_sel}, 32'h0);
            chk({nm, ".rvalid_rst"}, {28'b0, b_rv_2, b_rv_1, a_rv_2, a_rv_1}, 32'h0);
        end
        if ((eg1 && !w1) || (eg2 && !w2)) begin
            e.own = eg2; e.data = erd;
            e.due = cyc + 2; sb_a.push_back(e);
            e.due = cyc + 1; sb_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0,0,0,12'h0,32'h0, 0,0,0,12'h0,32'h0, 0,0,32'h0, "idle");
    endtask

    initial begin
        rst = 1; mem_clr = 1;
        req_1 = 0; req_2 = 0; lock_1 = 0; lock_2 = 0; we_1 = 0; we_2 = 0;
        addr_1 = 0; addr_2 = 0; wdata_1 = 0; wdata_2 = 0;

        // Reset with both requesting: nothing granted.
        step(1, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 0,0,32'h0, "rst0");
        step(1, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 0,0,32'h0, "rst1");
        mem_clr = 0;

        // Conflict after reset: 1, 2, 1, 2.
        step(0, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 1,0,32'hA5A50020, "conf0");
        step(0, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 0,1,32'hA5A50030, "conf1");
        step(0, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 1,0,32'hA5A50020, "conf2");
        step(0, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 0,1,32'hA5A50030, "conf3");
        idle(3);

        // Single read by requester 2.
        step(0, 0,0,0,12'h000,32'h0, 1,0,0,12'h010,32'h0, 0,1,32'hDEADBEEF, "single");
        idle(3);

        // Locked burst of four writes by requester 1 while requester 2 waits.
        for (int k = 0; k < 4; k++)
            step(0, 1,(k < 3),1,12'(k),32'hC0DE0000 + k, 1,0,0,12'h030,32'h0, 1,0,32'h0, "burst");
        step(0, 0,0,0,12'h000,32'h0, 1,0,0,12'h030,32'h0, 0,1,32'hA5A50030, "burst_rel");
        idle(3);

        // Write then read the same address from the other requester.
        step(0, 1,0,1,12'h0FF,32'h12345678, 0,0,0,12'h000,32'h0, 1,0,32'h0, "wr");
        step(0, 0,0,0,12'h000,32'h0, 1,0,0,12'h0FF,32'h0, 0,1,32'h12345678, "rd_after_wr");
        idle(3);

        // Reset while a read is in flight; then requester 1 must win the next conflict.
        step(0, 1,0,0,12'h020,32'h0, 0,0,0,12'h000,32'h0, 1,0,32'hA5A50020, "pre_rst");
        step(1, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 0,0,32'h0, "mid_rst");
        idle(4);
        step(0, 1,0,0,12'h020,32'h0, 1,0,0,12'h030,32'h0, 1,0,32'hA5A50020, "post_rst0");
        step(0, 0,0,0,12'h000,32'h0, 1,0,0,12'h030,32'h0, 0,1,32'hA5A50030, "post_rst1");
        idle(3);

        // Eight back-to-back reads alternating owners.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                step(0, 1,0,0,12'h040 + 12'(k),32'h0, 0,0,0,12'h000,32'h0, 1,0,32'hA5A50040 + k, "b2b");
            else
                step(0, 0,0,0,12'h000,32'h0, 1,0,0,12'h040 + 12'(k),32'h0, 0,1,32'hA5A50040 + k, "b2b");
        end
        idle(4);

        chk("sb_a_drained", sb_a.size(), 32'h0);
        chk("sb_b_drained", sb_b.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
